// File: rtl/tmds_rx_pkg.sv
// Shared TMDS symbol constants, decode payload and receiver state encoding.
package tmds_rx_pkg;

    localparam int unsigned SYM_W  = 10;
    localparam int unsigned DATA_W = 8;

    localparam logic [SYM_W-1:0] CTRL_00 = 10'b1101010100;
    localparam logic [SYM_W-1:0] CTRL_01 = 10'b0010101011;
    localparam logic [SYM_W-1:0] CTRL_10 = 10'b0101010100;
    localparam logic [SYM_W-1:0] CTRL_11 = 10'b1010101011;

    localparam logic [SYM_W-1:0] GUARD_A = 10'b1011001100;
    localparam logic [SYM_W-1:0] GUARD_B = 10'b0100110011;

    // Entry n is the 10-bit code for nibble n.
    localparam logic [15:0][SYM_W-1:0] TERC4_TABLE = {
        10'b1011000011, 10'b0101100011, 10'b1001110001, 10'b1010001110,
        10'b1011000110, 10'b0110011100, 10'b0100111001, 10'b1011001100,
        10'b0100111100, 10'b0110001110, 10'b0100011110, 10'b0101110001,
        10'b1011100010, 10'b1011100100, 10'b1001100011, 10'b1010011100
    };

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_LOCKED = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic              is_ctrl;
        logic [1:0]        c;
        logic              is_terc4;
        logic [3:0]        terc4;
        logic              is_guard;
        logic [DATA_W-1:0] d;
    } sym_t;

endpackage

// File: rtl/tmds_sym_decode.sv
// Combinational classification and decode of one 10-bit TMDS symbol.
module tmds_sym_decode
    import tmds_rx_pkg::*;
(
    input  logic [SYM_W-1:0] din,
    output sym_t             sym_c
);

    logic [DATA_W-1:0] q_c;
    logic              terc_hit_c;
    logic [3:0]        terc_nib_c;

    always_comb begin
        sym_c      = '0;
        q_c        = din[9] ? ~din[DATA_W-1:0] : din[DATA_W-1:0];
        terc_hit_c = 1'b0;
        terc_nib_c = 4'd0;

        unique case (din)
            CTRL_00: begin sym_c.is_ctrl = 1'b1; sym_c.c = 2'b00; end
            CTRL_01: begin sym_c.is_ctrl = 1'b1; sym_c.c = 2'b01; end
            CTRL_10: begin sym_c.is_ctrl = 1'b1; sym_c.c = 2'b10; end
            CTRL_11: begin sym_c.is_ctrl = 1'b1; sym_c.c = 2'b11; end
            default: ;
        endcase

        for (int n = 0; n < 16; n++) begin
            if (din == TERC4_TABLE[n]) begin
                terc_hit_c = 1'b1;
                terc_nib_c = 4'(n);
            end
        end
        // A control token never doubles as a TERC4 symbol.
        sym_c.is_terc4 = terc_hit_c && !sym_c.is_ctrl;
        sym_c.terc4    = terc_nib_c;
        sym_c.is_guard = (din == GUARD_A) || (din == GUARD_B);

        // TMDS transition-minimised decode: XOR or XNOR chain selected by din[8].
        sym_c.d[0] = q_c[0];
        for (int i = 1; i < DATA_W; i++) begin
            sym_c.d[i] = din[8] ? (q_c[i] ^ q_c[i-1]) : ~(q_c[i] ^ q_c[i-1]);
        end
    end

endmodule

// File: rtl/tmds_rx_channel.sv
// One TMDS receive lane: word alignment via bitslip requests plus registered symbol decode.
module tmds_rx_channel
    import tmds_rx_pkg::*;
#(
    parameter int unsigned LOCK_TOKENS   = 16,
    parameter int unsigned SEARCH_WINDOW = 4096,
    parameter int unsigned SLIP_WAIT     = 8,
    parameter int unsigned LOSS_WINDOW   = 4096
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [SYM_W-1:0] din,
    output logic             bitslip,
    output logic             aligned,
    output logic [3:0]       slip_cnt,
    output logic             is_ctrl,
    output logic [1:0]       c,
    output logic             is_terc4,
    output logic [3:0]       terc4,
    output logic             is_guard,
    output logic [7:0]       d
);

    // Run counter must be able to hold LOCK_TOKENS itself.
    localparam int unsigned RUN_W  = $clog2(LOCK_TOKENS + 1);
    localparam int unsigned WIN_W  = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
    localparam int unsigned WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
    localparam int unsigned GAP_W  = (LOSS_WINDOW > 1) ? $clog2(LOSS_WINDOW) : 1;

    logic [SYM_W-1:0]  din_q, din_d;
    sym_t              sym_q, sym_d, sym_c;
    rx_state_e         state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [3:0]        slip_cnt_q, slip_cnt_d;
    logic              bitslip_q, bitslip_d;
    logic              aligned_q, aligned_d;

    tmds_sym_decode u_dec (
        .din   (din_q),
        .sym_c (sym_c)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            din_q      <= '0;
            sym_q      <= '0;
            state_q    <= ST_SEARCH;
            run_q      <= '0;
            win_q      <= '0;
            wait_q     <= '0;
            gap_q      <= '0;
            slip_cnt_q <= '0;
            bitslip_q  <= 1'b0;
            aligned_q  <= 1'b0;
        end else begin
            din_q      <= din_d;
            sym_q      <= sym_d;
            state_q    <= state_d;
            run_q      <= run_d;
            win_q      <= win_d;
            wait_q     <= wait_d;
            gap_q      <= gap_d;
            slip_cnt_q <= slip_cnt_d;
            bitslip_q  <= bitslip_d;
            aligned_q  <= aligned_d;
        end
    end

    // Alignment FSM runs on the registered decode (stage 2 output).
    always_comb begin
        din_d      = din;
        sym_d      = sym_c;
        state_d    = state_q;
        run_d      = run_q;
        win_d      = win_q;
        wait_d     = wait_q;
        gap_d      = gap_q;
        slip_cnt_d = slip_cnt_q;
        bitslip_d  = 1'b0;
        aligned_d  = aligned_q;

        unique case (state_q)
            ST_SEARCH: begin
                if (!sym_q.is_ctrl) begin
                    run_d = '0;
                end else if (run_q != RUN_W'(LOCK_TOKENS)) begin
                    run_d = run_q + RUN_W'(1);
                end
                if (win_q != WIN_W'(SEARCH_WINDOW - 1)) begin
                    win_d = win_q + WIN_W'(1);
                end
                // Lock wins over window expiry on the same cycle.
                if (sym_q.is_ctrl && (run_q == RUN_W'(LOCK_TOKENS - 1))) begin
                    state_d   = ST_LOCKED;
                    aligned_d = 1'b1;
                    run_d     = '0;
                    win_d     = '0;
                    gap_d     = '0;
                end else if (win_q == WIN_W'(SEARCH_WINDOW - 1)) begin
                    state_d    = ST_SLIP;
                    bitslip_d  = 1'b1;
                    slip_cnt_d = (slip_cnt_q == 4'd9) ? 4'd0 : slip_cnt_q + 4'd1;
                    wait_d     = '0;
                    run_d      = '0;
                    win_d      = '0;
                end
            end
            ST_SLIP: begin
                run_d = '0;
                win_d = '0;
                if (wait_q == WAIT_W'(SLIP_WAIT - 1)) begin
                    state_d = ST_SEARCH;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_LOCKED: begin
                if (sym_q.is_ctrl) begin
                    gap_d = '0;
                end else if (gap_q == GAP_W'(LOSS_WINDOW - 1)) begin
                    state_d   = ST_SEARCH;
                    aligned_d = 1'b0;
                    gap_d     = '0;
                    run_d     = '0;
                    win_d     = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d   = ST_SEARCH;
                aligned_d = 1'b0;
            end
        endcase
    end

    assign bitslip  = bitslip_q;
    assign aligned  = aligned_q;
    assign slip_cnt = slip_cnt_q;
    assign is_ctrl  = sym_q.is_ctrl;
    assign c        = sym_q.c;
    assign is_terc4 = sym_q.is_terc4;
    assign terc4    = sym_q.terc4;
    assign is_guard = sym_q.is_guard;
    assign d        = sym_q.d;

endmodule

// File: tb/tb_tmds_rx_channel.sv
// Directed bench for tmds_rx_channel with a bit-rotating IDES10 model driven by bitslip.
module tb_tmds_rx_channel;

    localparam int unsigned SW = 4096;
    localparam int unsigned SLW = 8;
    localparam int unsigned LW = 4096;
    localparam logic [9:0] TOK00 = 10'b1101010100;
    localparam logic [9:0] DATA0 = 10'b0100000000;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [9:0] din = '0;
    logic       bitslip, aligned, is_ctrl, is_terc4, is_guard;
    logic [3:0] slip_cnt, terc4;
    logic [1:0] c;
    logic [7:0] d;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int slips = 0;
    int last_slip = -1;
    int rot = 0;
    int slips_before = 0;
    logic [9:0] base = '0;

    tmds_rx_channel dut (
        .clk      (clk),
        .resetn   (resetn),
        .din      (din),
        .bitslip  (bitslip),
        .aligned  (aligned),
        .slip_cnt (slip_cnt),
        .is_ctrl  (is_ctrl),
        .c        (c),
        .is_terc4 (is_terc4),
        .terc4    (terc4),
        .is_guard (is_guard),
        .d        (d)
    );

    always #5 clk = ~clk;

    // Word as seen by a deserializer whose word boundary is k bits late.
    function automatic logic [9:0] rotw(input logic [9:0] w, input int k);
        logic [19:0] ww;
        ww = {w, w};
        return ww[k +: 10];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [9:0] w);
        base = w;
        din  = rotw(w, rot);
    endtask

    // Advance one clock, model the IDES rotation on bitslip, present next word.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bitslip) begin
            if (last_slip >= 0) chk("slip_spacing", 32'(cyc - last_slip), 32'(SW + SLW));
            last_slip = cyc;
            slips++;
            rot = (rot + 1) % 10;
        end
        din = rotw(base, rot);
    endtask

    task automatic show(input logic [9:0] w);
        drive(w);
        step();
        step();
    endtask

    task automatic do_reset(input int start_rot);
        resetn = 1'b0;
        rot = start_rot;
        last_slip = -1;
        slips = 0;
        drive(DATA0);
        repeat (3) begin @(posedge clk); #1; end
        resetn = 1'b1;
    endtask

    initial begin
        // Reset held with random input: everything stays zero.
        resetn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            din = 10'($urandom);
        end
        chk("reset_outputs", 32'({bitslip, aligned, slip_cnt, is_ctrl, c, is_terc4, terc4, is_guard, d}), 32'd0);
        drive(DATA0);
        resetn = 1'b1;
        repeat (4) step();
        chk("post_reset_aligned", 32'(aligned), 32'd0);
        chk("post_reset_is_ctrl", 32'(is_ctrl), 32'd0);

        // Aligned token stream: lock after 16 tokens + 2 cycles.
        drive(TOK00);
        repeat (17) step();
        chk("lock_not_early", 32'(aligned), 32'd0);
        step();
        chk("lock_edge", 32'(aligned), 32'd1);
        chk("lock_is_ctrl", 32'(is_ctrl), 32'd1);
        chk("lock_c", 32'(c), 32'd0);
        chk("tok_d", 32'(d), 32'hFD);
        chk("tok_is_terc4", 32'(is_terc4), 32'd0);
        repeat (2) step();
        chk("lock_held", 32'(aligned), 32'd1);
        chk("no_slip_aligned", 32'(slips), 32'd0);

        // Stream rotated by 3 bits: seven slips bring it back to alignment.
        do_reset(3);
        drive(TOK00);
        for (int i = 0; i < 12 * int'(SW + SLW) && !aligned; i++) step();
        chk("rot_lock", 32'(aligned), 32'd1);
        chk("rot_slips", 32'(slips), 32'd7);
        chk("rot_slip_cnt", 32'(slip_cnt), 32'd7);
        chk("rot_c", 32'(c), 32'd0);
        last_slip = -1;

        // Data decode.
        show(DATA0);
        chk("d_0100000000", 32'(d), 32'h00);
        chk("ctrl_0100000000", 32'(is_ctrl), 32'd0);
        show(10'b1011111111);
        chk("d_1011111111", 32'(d), 32'hFE);
        chk("ctrl_1011111111", 32'(is_ctrl), 32'd0);
        show(10'b0100000001);
        chk("d_0100000001", 32'(d), 32'h03);
        show(10'b1000000011);
        chk("d_1000000011", 32'(d), 32'hFA);

        // TERC4, guard bands and the other control tokens.
        show(10'b1010011100);
        chk("terc_flag_0", 32'(is_terc4), 32'd1);
        chk("terc_nib_0", 32'(terc4), 32'd0);
        chk("terc_guard_0", 32'(is_guard), 32'd0);
        show(10'b1011001100);
        chk("terc_flag_8", 32'(is_terc4), 32'd1);
        chk("terc_nib_8", 32'(terc4), 32'd8);
        chk("guard_a", 32'(is_guard), 32'd1);
        show(10'b0100110011);
        chk("guard_b", 32'(is_guard), 32'd1);
        chk("guard_b_terc", 32'(is_terc4), 32'd0);
        show(10'b0010101011);
        chk("ctrl01", 32'({is_ctrl, c, is_terc4}), 32'b1010);
        show(10'b0101010100);
        chk("ctrl10", 32'({is_ctrl, c, is_terc4}), 32'b1100);
        show(10'b1010101011);
        chk("ctrl11", 32'({is_ctrl, c, is_terc4}), 32'b1110);
        chk("decode_kept_lock", 32'(aligned), 32'd1);

        // Loss of lock after LOSS_WINDOW non-control symbols, then search expiry.
        drive(TOK00);
        repeat (4) step();
        slips_before = slips;
        drive(DATA0);
        repeat (LW + 1) step();
        chk("loss_not_early", 32'(aligned), 32'd1);
        step();
        chk("loss_edge", 32'(aligned), 32'd0);
        repeat (SW - 1) step();
        chk("search_no_early_slip", 32'(bitslip), 32'd0);
        chk("locked_no_slip", 32'(slips), 32'(slips_before));
        step();
        chk("search_slip", 32'(bitslip), 32'd1);
        chk("slip_cnt_8", 32'(slip_cnt), 32'd8);

        // Reset in the middle of SLIP aborts the wait.
        repeat (3) step();
        resetn = 1'b0;
        #2;
        chk("slip_abort_bitslip", 32'(bitslip), 32'd0);
        chk("slip_abort_cnt", 32'(slip_cnt), 32'd0);
        chk("slip_abort_aligned", 32'(aligned), 32'd0);
        slips_before = slips;
        repeat (2) step();
        resetn = 1'b1;
        rot = 0;
        repeat (20) step();
        chk("after_abort_no_slip", 32'(slips), 32'(slips_before));
        chk("after_abort_cnt", 32'(slip_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
